// File: rtl/jw_dispatcher_if.sv
// Signal bundle between the frame dispatcher, its iteration worker and the Avalon-MM write port.
// The master side is the dispatcher; the slave side is the environment (worker, memory, frame control).
interface jw_dispatcher_if;
    logic        frame_start;
    logic        frame_done;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        JW_start;
    logic        JW_ready;
    logic        JW_done;
    logic [7:0]  pixel;
    logic        MC_busy;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    // Observation-only copy of the dispatcher state (0 IDLE, 1 ISSUE, 2 WAIT_CALC, 3 WRITE, 4 ADVANCE, 5 DONE).
    logic [2:0]  dbg_state;

    modport master (
        input  frame_start, JW_ready, JW_done, pixel, avm_waitrequest,
        output frame_done, x, y, JW_start, MC_busy, avm_address, avm_write, avm_writedata, dbg_state
    );

    modport slave (
        output frame_start, JW_ready, JW_done, pixel, avm_waitrequest,
        input  frame_done, x, y, JW_start, MC_busy, avm_address, avm_write, avm_writedata, dbg_state
    );
endinterface

// File: rtl/jw_dispatcher.sv
// Raster-scan dispatcher: walks every pixel of a frame, launches the worker once per pixel and
// writes each 8-bit result to SDRAM as a 32-bit word at OFFSET + (y*H_RES + x)*BYTES_PER_PIXEL.
//
// Handshakes: JW_start may pulse only while JW_ready=1; JW_done is honoured only while waiting for
// a result; an Avalon write holds address/data with avm_write=1 until a cycle with avm_waitrequest=0.
module jw_dispatcher #(
    parameter int          H_RES           = 640,
    parameter int          V_RES           = 480,
    parameter logic [31:0] OFFSET          = 32'h08000000,
    parameter int          BYTES_PER_PIXEL = 4
) (
    input  logic           clk,
    input  logic           rst,
    jw_dispatcher_if.master bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_CALC = 3'd2,
        WRITE     = 3'd3,
        ADVANCE   = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [9:0]  x_q;
    logic [9:0]  y_q;
    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic [7:0]  pixel_q;
    logic        last_col;
    logic        last_row;
    logic [31:0] lin_index;

    assign last_col = (x_q == 10'(H_RES - 1));
    assign last_row = (y_q == 10'(V_RES - 1));

    // Address is derived from the held coordinates, so it is stable for the whole write
    // and falls back to OFFSET whenever reset clears x and y.
    assign lin_index         = 32'(y_q) * 32'(H_RES) + 32'(x_q);
    assign bus.avm_address   = OFFSET + lin_index * 32'(BYTES_PER_PIXEL);
    assign bus.avm_writedata = {24'h000000, pixel_q};
    assign bus.x             = x_q;
    assign bus.y             = y_q;
    assign bus.dbg_state     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            pixel_q <= 8'd0;
        end else begin
            state <= state_next;
            x_q   <= x_next;
            y_q   <= y_next;
            if (state == WAIT_CALC && bus.JW_done) begin
                pixel_q <= bus.pixel;
            end
        end
    end

    always_comb begin
        state_next     = state;
        x_next         = x_q;
        y_next         = y_q;
        bus.JW_start   = 1'b0;
        bus.MC_busy    = 1'b0;
        bus.avm_write  = 1'b0;
        bus.frame_done = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.frame_start) begin
                    x_next     = 10'd0;
                    y_next     = 10'd0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.JW_ready) begin
                    bus.JW_start = 1'b1;
                    state_next   = WAIT_CALC;
                end
            end
            WAIT_CALC: begin
                if (bus.JW_done) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                bus.avm_write = 1'b1;
                bus.MC_busy   = 1'b1;
                if (!bus.avm_waitrequest) begin
                    state_next = ADVANCE;
                end
            end
            ADVANCE: begin
                // The final pixel keeps its coordinates; everything else steps in raster order.
                if (last_col && last_row) begin
                    state_next = DONE;
                end else begin
                    state_next = ISSUE;
                    if (last_col) begin
                        x_next = 10'd0;
                        y_next = y_q + 10'd1;
                    end else begin
                        x_next = x_q + 10'd1;
                    end
                end
            end
            DONE: begin
                bus.frame_done = 1'b1;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_jw_dispatcher.sv
// Randomised bench for jw_dispatcher on a 4x2 frame: a worker/memory model drives the inputs,
// a scoreboard predicts every accepted write from a linear pixel counter.
module tb_jw_dispatcher;

    localparam int          H      = 4;
    localparam int          V      = 2;
    localparam int          TOTAL  = H * V;
    localparam logic [31:0] OFFSET = 32'h08000000;
    localparam logic [31:0] BPP    = 32'd4;
    localparam logic [2:0]  ST_IDLE  = 3'd0;
    localparam logic [2:0]  ST_ISSUE = 3'd1;
    localparam logic [2:0]  ST_WRITE = 3'd3;

    logic clk;
    logic rst;
    jw_dispatcher_if bus ();

    jw_dispatcher #(
        .H_RES(H), .V_RES(V), .OFFSET(OFFSET), .BYTES_PER_PIXEL(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- shared state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    int          done_cnt;
    bit          start_seen;
    bit          immediate;
    int          wr_mode;
    logic [31:0] target_addr;
    bit          lat_check;
    int          hold_idx;
    int          a5_idx;
    int          tgt_cycles;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- worker model (drives JW_ready / JW_done / pixel) ----------------
    initial begin
        int  w_cnt;
        int  hold_left;
        bit  w_busy;
        int  k;
        bus.JW_ready = 1'b1;
        bus.JW_done  = 1'b0;
        bus.pixel    = 8'd0;
        w_busy       = 1'b0;
        w_cnt        = 0;
        hold_left    = 0;
        done_cnt     = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.JW_done = 1'b0;
            if (rst) begin
                w_busy       = 1'b0;
                done_cnt     = 0;
                hold_left    = 0;
                bus.JW_ready = 1'b1;
                exp_q.delete();
                continue;
            end
            if (start_seen) begin
                w_busy = 1'b1;
                w_cnt  = immediate ? 0 : $urandom_range(0, 3);
            end
            if (w_busy) begin
                if (w_cnt == 0) begin
                    k           = done_cnt % TOTAL;
                    bus.pixel   = (k == a5_idx) ? 8'hA5 : 8'($urandom_range(0, 255));
                    bus.JW_done = 1'b1;
                    exp_q.push_back({OFFSET + 32'(k) * BPP, 24'h000000, bus.pixel});
                    done_cnt++;
                    w_busy = 1'b0;
                    if ((done_cnt % TOTAL) == hold_idx) hold_left = 8;
                end else begin
                    w_cnt--;
                end
            end else if (!immediate && bus.avm_write && $urandom_range(0, 2) == 0) begin
                // Stray completion while the result is being written: must not disturb the write.
                bus.JW_done = 1'b1;
                bus.pixel   = 8'($urandom_range(0, 255));
            end
            if (hold_left > 0) begin
                bus.JW_ready = 1'b0;
                hold_left--;
            end else if (w_busy) begin
                bus.JW_ready = 1'b0;
            end else begin
                bus.JW_ready = immediate ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
        end
    end

    // ---------------- memory slave model (drives avm_waitrequest) ----------------
    initial begin
        int stall_cnt;
        stall_cnt           = 0;
        bus.avm_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (wr_mode)
                1: begin
                    bus.avm_waitrequest = bus.avm_write && ($urandom_range(0, 2) == 0);
                    stall_cnt = 0;
                end
                2: begin
                    if (bus.avm_write && bus.avm_address == target_addr && stall_cnt < 3) begin
                        bus.avm_waitrequest = 1'b1;
                        stall_cnt++;
                    end else begin
                        bus.avm_waitrequest = 1'b0;
                    end
                end
                3: begin
                    bus.avm_waitrequest = bus.avm_write && (bus.avm_address == target_addr);
                    stall_cnt = 0;
                end
                default: begin
                    bus.avm_waitrequest = 1'b0;
                    stall_cnt = 0;
                end
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int frame_done_cnt = 0;
    initial begin
        int          writes_seen;
        int          cyc;
        int          last_start;
        int          k;
        bit          prev_stall;
        bit          prev_fd;
        logic [31:0] h_addr;
        logic [31:0] h_data;
        logic [9:0]  h_x;
        logic [9:0]  h_y;
        logic [63:0] e;
        writes_seen = 0;
        cyc         = 0;
        last_start  = -1;
        prev_stall  = 1'b0;
        prev_fd     = 1'b0;
        start_seen  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            start_seen = bus.JW_start;
            if (rst) begin
                writes_seen = 0;
                prev_stall  = 1'b0;
                prev_fd     = 1'b0;
                last_start  = -1;
                continue;
            end
            check(bus.MC_busy == bus.avm_write, "mc_busy_tracks_write", 64'(bus.MC_busy), 64'(bus.avm_write));
            check(bus.avm_write == (bus.dbg_state == ST_WRITE), "write_only_in_write",
                  64'(bus.avm_write), 64'(bus.dbg_state == ST_WRITE));
            if (bus.dbg_state == ST_ISSUE)
                check(bus.JW_start == bus.JW_ready, "issue_start_follows_ready", 64'(bus.JW_start), 64'(bus.JW_ready));
            if (prev_stall) begin
                check(bus.avm_write == 1'b1, "stall_write_held", 64'(bus.avm_write), 64'd1);
                check(bus.avm_address == h_addr, "stall_addr_stable", 64'(bus.avm_address), 64'(h_addr));
                check(bus.avm_writedata == h_data, "stall_data_stable", 64'(bus.avm_writedata), 64'(h_data));
                check(bus.x == h_x && bus.y == h_y, "stall_xy_stable", {bus.y, bus.x}, {h_y, h_x});
            end
            if (bus.avm_write && !bus.avm_waitrequest) begin
                check(exp_q.size() != 0, "write_expected", 64'(bus.avm_address), 64'(exp_q.size()));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check(bus.avm_address == e[63:32], "write_addr", 64'(bus.avm_address), 64'(e[63:32]));
                    check(bus.avm_writedata == e[31:0], "write_data", 64'(bus.avm_writedata), 64'(e[31:0]));
                end
                writes_seen++;
            end
            prev_stall = bus.avm_write && bus.avm_waitrequest;
            h_addr     = bus.avm_address;
            h_data     = bus.avm_writedata;
            h_x        = bus.x;
            h_y        = bus.y;
            if (bus.JW_start) begin
                k = done_cnt % TOTAL;
                check(bus.x == 10'(k % H), "start_x", 64'(bus.x), 64'(k % H));
                check(bus.y == 10'(k / H), "start_y", 64'(bus.y), 64'(k / H));
                if (lat_check && last_start >= 0)
                    check(cyc - last_start == 4, "start_to_start_latency", 64'(cyc - last_start), 64'd4);
                last_start = cyc;
            end
            if (bus.frame_done) begin
                check(!prev_fd, "frame_done_single_cycle", 64'(prev_fd), 64'd0);
                check(writes_seen == TOTAL, "writes_per_frame", 64'(writes_seen), 64'(TOTAL));
                check(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 64'd0);
                frame_done_cnt++;
                writes_seen = 0;
                last_start  = -1;
            end
            prev_fd = bus.frame_done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(posedge clk);
        #1 bus.frame_start = 1'b1;
        @(posedge clk);
        #1 bus.frame_start = 1'b0;
    endtask

    task automatic wait_frame(input int budget, input bit noisy_start);
        bit got;
        got        = 1'b0;
        tgt_cycles = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.avm_write && bus.avm_address == target_addr) tgt_cycles++;
            if (bus.frame_done) begin
                got             = 1'b1;
                bus.frame_start = 1'b0;
            end else if (noisy_start) begin
                bus.frame_start = ($urandom_range(0, 7) == 0);
            end
        end
        bus.frame_start = 1'b0;
        check(got, "frame_done_within_budget", 64'(got), 64'd1);
    endtask

    task automatic idle_quiet(input int n);
        int extra;
        extra = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.frame_done || bus.JW_start) extra++;
        end
        check(extra == 0, "no_restart_after_frame", 64'(extra), 64'd0);
        check(bus.dbg_state == ST_IDLE, "idle_after_frame", 64'(bus.dbg_state), 64'(ST_IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit found;
        int fd_before;
        rst             = 1'b1;
        bus.frame_start = 1'b0;
        immediate       = 1'b1;
        wr_mode         = 0;
        lat_check       = 1'b0;
        hold_idx        = -1;
        a5_idx          = -1;
        target_addr     = OFFSET;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(bus.dbg_state == ST_IDLE, "reset_state", 64'(bus.dbg_state), 64'(ST_IDLE));
        check(bus.x == 10'd0 && bus.y == 10'd0, "reset_xy", {bus.y, bus.x}, 64'd0);
        check(bus.avm_address == OFFSET, "reset_addr", 64'(bus.avm_address), 64'(OFFSET));
        check(bus.avm_writedata == 32'd0, "reset_data", 64'(bus.avm_writedata), 64'd0);
        check(!bus.avm_write && !bus.MC_busy, "reset_write_busy", {bus.avm_write, bus.MC_busy}, 64'd0);
        check(!bus.JW_start && !bus.frame_done, "reset_pulses", {bus.JW_start, bus.frame_done}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Frame 1: everything immediate, back-to-back pixel cadence.
        lat_check = 1'b1;
        fd_before = frame_done_cnt;
        pulse_start();
        wait_frame(200, 1'b0);
        idle_quiet(10);
        check(frame_done_cnt - fd_before == 1, "frame1_one_done", 64'(frame_done_cnt - fd_before), 64'd1);
        lat_check = 1'b0;

        // Frame 2: 3-cycle stall on pixel (1,0), ready held low before pixel 4, pixel 2 = A5.
        wr_mode     = 2;
        target_addr = OFFSET + 32'd4;
        hold_idx    = 4;
        a5_idx      = 2;
        pulse_start();
        wait_frame(200, 1'b0);
        check(tgt_cycles == 4, "stalled_write_cycles", 64'(tgt_cycles), 64'd4);
        idle_quiet(10);
        hold_idx = -1;
        a5_idx   = -1;

        // Random frames with noisy frame_start, stray JW_done and random stalls.
        immediate = 1'b0;
        wr_mode   = 1;
        repeat (3) begin
            fd_before = frame_done_cnt;
            pulse_start();
            wait_frame(600, 1'b1);
            idle_quiet(10);
            check(frame_done_cnt - fd_before == 1, "random_frame_one_done", 64'(frame_done_cnt - fd_before), 64'd1);
        end

        // Reset in the middle of the write to pixel (2,1).
        immediate   = 1'b1;
        wr_mode     = 3;
        target_addr = OFFSET + 32'd24;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.avm_write && bus.avm_address == target_addr) found = 1'b1;
        end
        check(found, "reached_write_2_1", 64'(found), 64'd1);
        check(bus.x == 10'd2 && bus.y == 10'd1, "write_2_1_coords", {bus.y, bus.x}, {10'd1, 10'd2});
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check(!bus.avm_write && !bus.MC_busy, "rst_abandons_write", {bus.avm_write, bus.MC_busy}, 64'd0);
        check(bus.x == 10'd0 && bus.y == 10'd0, "rst_clears_xy", {bus.y, bus.x}, 64'd0);
        check(bus.dbg_state == ST_IDLE, "rst_to_idle", 64'(bus.dbg_state), 64'(ST_IDLE));
        check(bus.avm_address == OFFSET, "rst_addr_offset", 64'(bus.avm_address), 64'(OFFSET));
        wr_mode = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        pulse_start();
        wait_frame(200, 1'b0);
        idle_quiet(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jw_dispatcher.md
JW_DISPATCHER -- requirements
Module: jw_dispatcher

Interface
REQ-001 SHALL have parameter H_RES, default 640, pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, lines per frame.
REQ-003 SHALL have parameter OFFSET, default 32'h08000000, SDRAM byte address of pixel (0,0).
REQ-004 SHALL have parameter BYTES_PER_PIXEL, default 4, address stride per pixel.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk  in  1  rising-edge clock.
REQ-007 SHALL have port rst  in  1  synchronous active-high reset.
REQ-008 SHALL have port frame_start  in  1  begins a full-frame scan.
REQ-009 SHALL have port frame_done  out  1  one-cycle pulse when the last pixel write completes.
REQ-010 SHALL have port x  out  10  current pixel column driven to the worker.
REQ-011 SHALL have port y  out  10  current pixel row driven to the worker.
REQ-012 SHALL have port JW_start  out  1  one-cycle pulse launching a worker calculation.
REQ-013 SHALL have port JW_ready  in  1  worker idle and able to accept JW_start.
REQ-014 SHALL have port JW_done  in  1  worker result valid on pixel.
REQ-015 SHALL have port pixel  in  8  worker iteration result.
REQ-016 SHALL have port MC_busy  out  1  memory write in progress; worker holds off.
REQ-017 SHALL have port avm_address  out  32  write byte address.
REQ-018 SHALL have port avm_write  out  1  write request.
REQ-019 SHALL have port avm_writedata  out  32  write data.
REQ-020 SHALL have port avm_waitrequest  in  1  slave stall; write accepted when avm_write=1 and avm_waitrequest=0.

Function
REQ-021 SHALL implement states IDLE, ISSUE, WAIT_CALC, WRITE, ADVANCE, DONE.
REQ-022 IDLE: frame_start=1 -> x=0, y=0, next ISSUE; frame_start in any other state SHALL be ignored.
REQ-023 ISSUE: JW_ready=1 -> JW_start=1 for exactly that cycle, next WAIT_CALC; JW_ready=0 -> stay, JW_start=0.
REQ-024 WAIT_CALC: JW_done=1 -> register pixel into pixel_q, next WRITE; else stay.
REQ-025 WRITE: avm_write=1, MC_busy=1, avm_address and avm_writedata held constant until avm_waitrequest=0, then next ADVANCE.
REQ-026 avm_address SHALL equal OFFSET + (y*H_RES + x)*BYTES_PER_PIXEL, computed in 32 bits, modulo 2^32.
REQ-027 avm_writedata SHALL equal {24'h000000, pixel_q}.
REQ-028 ADVANCE: x<H_RES-1 -> x+1; x=H_RES-1 -> x=0 and, if y<V_RES-1, y+1, next ISSUE; x=H_RES-1 and y=V_RES-1 -> next DONE with x,y unchanged.
REQ-029 DONE: frame_done=1 for one cycle, next IDLE.
REQ-030 x,y SHALL be stable from ISSUE entry until ADVANCE.
REQ-031 JW_done outside WAIT_CALC SHALL be ignored; pixel SHALL be sampled only in WAIT_CALC.
REQ-032 MC_busy, avm_write SHALL be 0 in every state except WRITE.
REQ-033 Per-pixel minimum latency from JW_start to next JW_start SHALL be 4 cycles (WAIT_CALC, WRITE, ADVANCE, ISSUE) with JW_done and JW_ready immediate and no waitrequest.

Reset
REQ-034 rst=1 at a clock edge SHALL force IDLE, x=0, y=0, pixel_q=0, JW_start=0, frame_done=0, MC_busy=0, avm_write=0, avm_address=OFFSET, avm_writedata=0.
REQ-035 rst SHALL take priority over all inputs, including mid-write; an in-flight write SHALL be abandoned.

Verification
REQ-036 H_RES=4, V_RES=2, worker ready/done immediate, waitrequest=0: frame_start -> 8 writes at 0x08000000..0x0800001C step 4, then one frame_done pulse.
REQ-037 waitrequest held 1 for 3 cycles on pixel (1,0): avm_write, avm_address=0x08000004, data stable all 4 cycles; one write counted.
REQ-038 JW_ready=0 for 5 cycles in ISSUE: JW_start stays 0, then single pulse when JW_ready=1; x,y unchanged.
REQ-039 pixel=8'hA5 with JW_done -> avm_writedata=32'h000000A5; spurious JW_done in WRITE leaves data unchanged.
REQ-040 rst asserted during WRITE at (2,1): next cycle avm_write=0, MC_busy=0, x=y=0, IDLE; new frame_start restarts at 0x08000000.
REQ-041 frame_start pulsed during scan -> no restart; exactly one frame_done after last pixel (3,1).
